multiplier_seq_dsp: RTL
=======================

# multiplier_seq_dsp

- Parametrised signed A_W × B_W multiplier that time-multiplexes one 18×18 DSP multiplier.
- Operand A is split into SLICE_W-bit slices, LSB slice first. Each partial product is shifted and accumulated to give the full-precision product.
- Accepts a new operand pair every N cycles through a valid/ready handshake. Slices of consecutive operations overlap in the pipeline.
- Sits in datapaths where DSP count matters more than throughput.

## Interface
Parameters:
- A_W, 69: operand A width, signed, at least SLICE_W+2.
- B_W, 18: operand B width, signed, at most 18.
- SLICE_W, 17: unsigned slice width, at most 17.
- MUL_LAT, 2: multiplier pipeline depth in cycles, at least 1.
- SHIFT, 17: right shift applied at the output; only used when MULT_SEQ_ROUND_EN is defined.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_valid, in, 1: operand pair valid.
- i_a, in, A_W: signed multiplicand.
- i_b, in, B_W: signed multiplier.
- o_ready, out, 1: block can accept an operand pair this cycle.
- o_valid, out, 1: one-cycle pulse; o_c is valid in that cycle.
- o_c, out, P_W: signed product. P_W = A_W+B_W, or A_W+B_W-SHIFT when rounding is compiled in.

## Operation
- N = ceil((A_W-1)/SLICE_W). With the defaults, N = 4.
- Slices 0..N-2 are unsigned and zero-extended to 18 bits.
- Slice N-1 holds the remaining top bits, sign-extended to 18 bits.
- i_b is sign-extended to 18 bits.
- Transfer occurs when i_valid and o_ready are both high in the same cycle (cycle t0). i_a and i_b are captured at that edge.
- Issue counter k runs 0..N-1. Slice k drives the multiplier in cycle t0+1+k.
- o_ready is high when idle, and also during the cycle that issues slice N-1. This gives back-to-back acceptance with no bubble.
- Each issued slice carries tag bits first (k=0) and last (k=N-1) down a MUL_LAT+1 deep shift register alongside the product.
- Alignment stage: the 36-bit product is sign-extended and shifted left by k·SLICE_W into an accumulator width of A_W+B_W.
- Accumulator update:
  - on first: acc = aligned product (+ rounding constant, see Configuration);
  - otherwise: acc = acc + aligned product.
- When last reaches the accumulator, o_valid pulses and o_c is driven from acc.
- The full product always fits, including (-2^(A_W-1))·(-2^(B_W-1)). No overflow is possible.
- i_valid while o_ready is low: ignored, not queued. Inputs are not sampled.
- There is no output backpressure. The consumer must take o_c in the o_valid cycle.

## Timing
- Latency: o_valid occurs in cycle t0+N+MUL_LAT+2. With the defaults that is t0+8.
- Throughput: one result every N cycles.
- o_c holds its last value between pulses.
- Reset values: o_valid=0, o_c=0, o_ready=1, issue counter idle, all tags 0.
- Reset mid-operation: in-flight operations are discarded and no o_valid is produced for them. The first transfer after reset behaves exactly as from power-up.

## Configuration
- MULT_SEQ_ROUND_EN, defined:
  - on first, the accumulator is preloaded with 2^(SHIFT-1) (round half up);
  - o_c = acc[A_W+B_W-1:SHIFT], so P_W = A_W+B_W-SHIFT;
  - no added latency.
- MULT_SEQ_ROUND_EN, undefined: no preload, o_c = acc, P_W = A_W+B_W, SHIFT ignored.

## Structure
- Package multiplier_seq_pkg holds:
  - function calc_nslice(A_W, SLICE_W);
  - constant DSP_IN_W=18;
  - constant DSP_OUT_W=36.
- Sub-module dsp_mul_pipe: signed 18×18 multiply with MUL_LAT output registers, inferred into one DSP. It replaces the vendor IP instance. Tag bits stay in the parent.

## Test plan
- Defaults, a=3, b=5, single transfer at t0 → o_valid at t0+8, o_c=15, and no other pulses.
- a=-1, b=-1 → o_c=1. Then a=-2^68, b=-2^17 → o_c=2^85 (87-bit, no wrap).
- i_valid held high with operand pairs (7,9) then (-100000,131071):
  - transfers land at t0 and t0+4;
  - results 63 at t0+8 and -13107100000 at t0+12;
  - o_ready low in cycles t0+1..t0+3.
- i_rst asserted in cycle t0+5 of an operation:
  - o_valid stays 0;
  - o_ready=1 right after reset;
  - a new pair (2,2) yields 4 at the normal latency.
- Random 10,000 transfers with randomised i_valid gaps, A_W=35, B_W=12, MUL_LAT=3. Results match a reference model bit-exactly and in order.
- MULT_SEQ_ROUND_EN defined, SHIFT=17:
  - a=2^16, b=1 → o_c=1;
  - a=2^16-1, b=1 → o_c=0;
  - a=-2^16, b=1 → o_c=0.

Source files
------------

// File: rtl/multiplier_seq_pkg.sv
// Shared constants, state type and helpers for the
// sequential slice-by-slice DSP multiplier.
package multiplier_seq_pkg;

   localparam int DSP_IN_W  = 18;
   localparam int DSP_OUT_W = 36;

   typedef enum logic {
      S_IDLE,
      S_ISSUE
   } issue_st_t;

   // Number of A slices: ceil((a_w-1)/slice_w)
   function automatic int calc_nslice(
      input int a_w,
      input int slice_w
   );
      return (a_w - 1 + slice_w - 1) / slice_w;
   endfunction

endpackage

// File: rtl/multiplier_seq_dsp_mul.sv
// Signed 18x18 multiply with MUL_LAT output registers,
// written so synthesis maps it onto a single DSP block.
module dsp_mul_pipe
   import multiplier_seq_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input  logic                 i_clk,
   input  logic [DSP_IN_W-1:0]  i_a,
   input  logic [DSP_IN_W-1:0]  i_b,
   output logic [DSP_OUT_W-1:0] o_p
);

   logic signed [DSP_OUT_W-1:0] prod;
   logic [DSP_OUT_W-1:0] p_q [MUL_LAT];

   assign prod = $signed(i_a) * $signed(i_b);

   // Product pipeline, no reset so it packs into the DSP registers
   always_ff @(posedge i_clk) begin
      p_q[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) begin
         p_q[i] <= p_q[i-1];
      end
   end

   assign o_p = p_q[MUL_LAT-1];

endmodule

// File: rtl/multiplier_seq_dsp.sv
// Signed A_W x B_W multiplier time-sharing one 18x18 DSP.
// Define MULT_SEQ_ROUND_EN to round and drop SHIFT output LSBs.
module multiplier_seq_dsp
   import multiplier_seq_pkg::*;
#(
   parameter int A_W     = 69,
   parameter int B_W     = 18,
   parameter int SLICE_W = 17,
   parameter int MUL_LAT = 2,
   parameter int SHIFT   = 17
`ifdef MULT_SEQ_ROUND_EN
   , localparam bit RND_EN = 1'b1
`else
   , localparam bit RND_EN = 1'b0
`endif
   , localparam int P_W = A_W + B_W - (RND_EN ? SHIFT : 0)
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_valid,
   input  logic [A_W-1:0] i_a,
   input  logic [B_W-1:0] i_b,
   output logic           o_ready,
   output logic           o_valid,
   output logic [P_W-1:0] o_c
);

   localparam int N      = calc_nslice(A_W, SLICE_W);
   localparam int KW     = $clog2(N);
   localparam int ACC_W  = A_W + B_W;
   localparam int AX_W   = A_W + DSP_IN_W;
   localparam int RND_SH = RND_EN ? SHIFT : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   localparam logic [ACC_W-1:0] RND_K =
      RND_EN ? (ACC_W'(1) << (RND_SH - 1)) : '0;

   issue_st_t st, st_nxt;
   logic [KW-1:0] k, k_nxt;
   logic signed [A_W-1:0] a_r;
   logic signed [B_W-1:0] b_r;
   logic is_last, xfer;

   logic signed [AX_W-1:0] a_x;
   logic [DSP_IN_W-1:0] a_win, sl, b_x;
   logic [DSP_OUT_W-1:0] prod;

   logic [MUL_LAT:0] t_vld, t_first, t_last;
   logic [KW-1:0] t_k [MUL_LAT];

   logic [ACC_W-1:0] al, acc, acc_nxt;

   assign is_last = (st == S_ISSUE) && (k == K_LAST);
   assign o_ready = (st == S_IDLE) || is_last;
   assign xfer    = i_valid && o_ready;

   // Issue state and slice counter registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         st <= S_IDLE;
         k  <= '0;
      end else begin
         st <= st_nxt;
         k  <= k_nxt;
      end
   end

   // Next issue state: restart on accept, else walk slices
   always_comb begin
      st_nxt = st;
      k_nxt  = k;
      case (st)
         S_IDLE: begin
            if (i_valid) begin
               st_nxt = S_ISSUE;
               k_nxt  = '0;
            end
         end
         S_ISSUE: begin
            if (k == K_LAST) begin
               if (i_valid) k_nxt = '0;
               else st_nxt = S_IDLE;
            end else begin
               k_nxt = k + 1'b1;
            end
         end
         default: st_nxt = S_IDLE;
      endcase
   end

   // Operand capture on a handshake
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_r <= '0;
         b_r <= '0;
      end else if (xfer) begin
         a_r <= i_a;
         b_r <= i_b;
      end
   end

   // Pick slice k: low slices unsigned, top slice signed
   always_comb begin
      a_x   = AX_W'(a_r);
      a_win = DSP_IN_W'(a_x >>> (k * SLICE_W));
      sl    = '0;
      if (k == K_LAST) sl = a_win;
      else sl[SLICE_W-1:0] = a_win[SLICE_W-1:0];
      b_x = DSP_IN_W'(b_r);
   end

   dsp_mul_pipe #(
      .MUL_LAT (MUL_LAT)
   ) u_mul (
      .i_clk (i_clk),
      .i_a   (sl),
      .i_b   (b_x),
      .o_p   (prod)
   );

   // Tags and slice index travel beside the product
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         t_vld   <= '0;
         t_first <= '0;
         t_last  <= '0;
         for (int i = 0; i < MUL_LAT; i++) t_k[i] <= '0;
      end else begin
         t_vld   <= {t_vld[MUL_LAT-1:0], st == S_ISSUE};
         t_first <= {t_first[MUL_LAT-1:0],
                     (st == S_ISSUE) && (k == '0)};
         t_last  <= {t_last[MUL_LAT-1:0], is_last};
         t_k[0]  <= k;
         for (int i = 1; i < MUL_LAT; i++) t_k[i] <= t_k[i-1];
      end
   end

   // Align partial product to its slice weight
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) al <= '0;
      else al <= ACC_W'($signed(prod)) << (t_k[MUL_LAT-1] * SLICE_W);
   end

   assign acc_nxt = (t_first[MUL_LAT] ? RND_K : acc) + al;

   // Accumulate slices and publish on the last one
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc     <= '0;
         o_valid <= 1'b0;
         o_c     <= '0;
      end else begin
         o_valid <= t_vld[MUL_LAT] && t_last[MUL_LAT];
         if (t_vld[MUL_LAT]) acc <= acc_nxt;
         if (t_vld[MUL_LAT] && t_last[MUL_LAT])
            o_c <= acc_nxt[ACC_W-1:ACC_W-P_W];
      end
   end

endmodule
